// File: rtl/ysyx_220053_mul_iter.sv
// ysyx_220053_mul_iter: iterative radix-2 shift-add multiplier for the RV64M
// MUL/MULH/MULHSU/MULHU/MULW group. One conditional partial product is added
// per BUSY cycle through a WIDTH-bit adder built from 4-bit carry-lookahead
// cells. Operands are taken as magnitudes and the sign is fixed on DONE entry.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   flush               pipeline kill, aborts any operation (highest priority)
//   mul_valid/mul_ready operand handshake (mul_ready high only in IDLE)
//   mulw                32-bit word op, result sign-extended from bit 31
//   mul_signed[1:0]     11 s*s, 10 s*u, 00/01 u*u
//   multiplicand, multiplier  WIDTH-bit operands
//   out_valid/out_ready result handshake
//   result_hi, result_lo      high/low halves of the 2*WIDTH product
//
// Parameter WIDTH must be a multiple of 4 and at least 32.
// Optional macro YSYX_220053_MUL_EARLY_EXIT_EN: leave BUSY as soon as the
// remaining multiplier bits are zero and barrel-shift the accumulator into
// place; results are identical either way.

module ysyx_220053_mul_iter #(
   parameter int unsigned WIDTH = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             mul_valid,
   output logic             mul_ready,
   input  logic             mulw,
   input  logic [1:0]       mul_signed,
   input  logic [WIDTH-1:0] multiplicand,
   input  logic [WIDTH-1:0] multiplier,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result_hi,
   output logic [WIDTH-1:0] result_lo
);

   localparam int unsigned NCELL = WIDTH / 4;
   localparam int unsigned CW    = $clog2(WIDTH + 1);
   localparam int unsigned PW    = 2 * WIDTH;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           r_state;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_acc_hi;
   logic [WIDTH-1:0] r_acc_lo;
   logic [WIDTH-1:0] r_mcand;
   logic [WIDTH-1:0] r_mplr;
   logic             r_neg;
   logic             r_word;

   // Operand magnitude capture
   logic             w_a_sgn, w_b_sgn;
   logic             w_a_msb, w_b_msb;
   logic             w_a_neg, w_b_neg;
   logic [WIDTH-1:0] w_a_raw, w_b_raw;
   logic [WIDTH-1:0] w_a_tc,  w_b_tc;
   logic [WIDTH-1:0] w_a_mag, w_b_mag;

   always_comb begin
      w_a_sgn = mul_signed[1];
      w_b_sgn = mul_signed[1] & mul_signed[0];
      w_a_raw = mulw ? WIDTH'(multiplicand[31:0]) : multiplicand;
      w_b_raw = mulw ? WIDTH'(multiplier[31:0])   : multiplier;
      w_a_msb = mulw ? multiplicand[31] : multiplicand[WIDTH-1];
      w_b_msb = mulw ? multiplier[31]   : multiplier[WIDTH-1];
      w_a_neg = w_a_sgn & w_a_msb;
      w_b_neg = w_b_sgn & w_b_msb;
      w_a_tc  = ~w_a_raw + WIDTH'(1);
      w_b_tc  = ~w_b_raw + WIDTH'(1);
      // word ops keep the negated magnitude inside 32 bits
      w_a_mag = !w_a_neg ? w_a_raw : (mulw ? WIDTH'(w_a_tc[31:0]) : w_a_tc);
      w_b_mag = !w_b_neg ? w_b_raw : (mulw ? WIDTH'(w_b_tc[31:0]) : w_b_tc);
   end

   // Partial-product adder: chain of 4-bit carry-lookahead cells
   logic [WIDTH-1:0] w_addend;
   logic [WIDTH-1:0] w_sum;
   logic             w_cout;

   always_comb begin
      logic       c;
      logic [3:0] g;
      logic [3:0] p;
      logic [4:0] cc;
      c        = 1'b0;
      g        = '0;
      p        = '0;
      cc       = '0;
      w_sum    = '0;
      w_addend = r_mplr[0] ? r_mcand : '0;
      for (int k = 0; k < int'(NCELL); k++) begin
         g     = r_acc_hi[4*k +: 4] & w_addend[4*k +: 4];
         p     = r_acc_hi[4*k +: 4] ^ w_addend[4*k +: 4];
         cc[0] = c;
         cc[1] = g[0] | (p[0] & c);
         cc[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c);
         cc[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
               | (p[2] & p[1] & p[0] & c);
         cc[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
               | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & c);
         w_sum[4*k +: 4] = p ^ cc[3:0];
         c = cc[4];
      end
      w_cout = c;
   end

   // Termination and final alignment / sign fix
   logic [CW-1:0]     w_iters;
   logic              w_last;
   logic [CW-1:0]     w_shamt;
   logic [PW-1:0]     w_prod_sh;
   logic [PW-1:0]     w_prod_fx;
   logic signed [31:0] w_w32;

   always_comb begin
      w_iters = r_word ? CW'(32) : CW'(WIDTH);
`ifdef YSYX_220053_MUL_EARLY_EXIT_EN
      // r_cnt != 0 keeps the minimum latency at two cycles
      w_last  = (r_cnt == w_iters) || ((r_mplr == '0) && (r_cnt != '0));
`else
      w_last  = (r_cnt == w_iters);
`endif
      // after r_cnt iterations the product sits WIDTH-r_cnt bits too high
      w_shamt   = CW'(WIDTH) - r_cnt;
      w_prod_sh = {r_acc_hi, r_acc_lo} >> w_shamt;
      w_prod_fx = r_neg ? (~w_prod_sh + PW'(1)) : w_prod_sh;
      w_w32     = w_prod_fx[31:0];
   end

   // Control FSM and datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_acc_hi  <= '0;
         r_acc_lo  <= '0;
         r_mcand   <= '0;
         r_mplr    <= '0;
         r_neg     <= 1'b0;
         r_word    <= 1'b0;
         mul_ready <= 1'b1;
         out_valid <= 1'b0;
         result_hi <= '0;
         result_lo <= '0;
      end else if (flush) begin
         r_state   <= S_IDLE;
         mul_ready <= 1'b1;
         out_valid <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (mul_valid && mul_ready) begin
                  r_mcand   <= w_a_mag;
                  r_mplr    <= w_b_mag;
                  r_neg     <= w_a_neg ^ w_b_neg;
                  r_word    <= mulw;
                  r_acc_hi  <= '0;
                  r_acc_lo  <= '0;
                  r_cnt     <= '0;
                  mul_ready <= 1'b0;
                  r_state   <= S_BUSY;
               end
            end
            S_BUSY: begin
               if (w_last) begin
                  if (r_word) begin
                     result_hi <= '0;
                     result_lo <= WIDTH'(w_w32);
                  end else begin
                     result_hi <= w_prod_fx[PW-1:WIDTH];
                     result_lo <= w_prod_fx[WIDTH-1:0];
                  end
                  out_valid <= 1'b1;
                  r_state   <= S_DONE;
               end else begin
                  // adder carry-out becomes the MSB shifted in
                  r_acc_hi <= {w_cout, w_sum[WIDTH-1:1]};
                  r_acc_lo <= {w_sum[0], r_acc_lo[WIDTH-1:1]};
                  r_mplr   <= r_mplr >> 1;
                  r_cnt    <= r_cnt + CW'(1);
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  mul_ready <= 1'b1;
                  r_state   <= S_IDLE;
               end
            end
            default: begin
               out_valid <= 1'b0;
               mul_ready <= 1'b1;
               r_state   <= S_IDLE;
            end
         endcase
      end
   end

endmodule
